// File: rtl/uart_rx_frame_check_if.sv
// Bundle of signals between the RX bit sampler, the frame checker and the
// RX output register.
//
// Strobe semantics: frame_start and bit_valid are single-cycle qualifiers
// with no back-pressure. The checker consumes sampled_bit on every cycle
// bit_valid is high. frame_done is a one-cycle pulse that marks data_out and
// the error flags as freshly loaded. There is no ready signal; the checker
// keeps up with one bit per cycle.
interface uart_rx_frame_check_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  frame_start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic                  par_type;
  logic                  cnt_clr;
  logic                  busy;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  par_err;
  logic                  stop_err;
  logic [CNT_WIDTH-1:0]  par_err_cnt;
  logic [CNT_WIDTH-1:0]  stop_err_cnt;

  // Sampler / consumer side
  modport master (
    output frame_start, bit_valid, sampled_bit, par_en, par_type, cnt_clr,
    input  busy, frame_done, data_out, par_err, stop_err,
           par_err_cnt, stop_err_cnt
  );

  // Frame checker side
  modport slave (
    input  frame_start, bit_valid, sampled_bit, par_en, par_type, cnt_clr,
    output busy, frame_done, data_out, par_err, stop_err,
           par_err_cnt, stop_err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: assembles DATA_WIDTH data bits LSB-first after
// a confirmed start bit, checks optional even/odd parity and STOP_BITS stop
// bits, reports per-frame results and keeps saturating error counters.
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_rx_frame_check_if.slave    rx,
  output logic [1:0]              state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [3:0]           LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [1:0]            state;
  logic [3:0]            bit_cnt;     // data bit index, reused for stop bits
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  run_par;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  par_bad;
  logic                  stop_bad;

  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_err_q;
  logic                  stop_err_q;
  logic [CNT_WIDTH-1:0]  par_cnt;
  logic [CNT_WIDTH-1:0]  stop_cnt;

  logic                  frame_end;
  logic                  stop_flag;

  // Final stop strobe of the frame and the stop verdict including that bit
  always_comb begin
    frame_end = (state == S_STOP) && rx.bit_valid && (bit_cnt == LAST_STOP);
    stop_flag = stop_bad | ~rx.sampled_bit;
  end

  // Frame FSM, bit assembly, parity/stop tracking and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      data_sh    <= '0;
      run_par    <= 1'b0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx.frame_start) begin
            state      <= S_DATA;
            busy_q     <= 1'b1;
            bit_cnt    <= '0;
            run_par    <= 1'b0;
            par_en_q   <= rx.par_en;
            par_type_q <= rx.par_type;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
          end
        end
        S_DATA: begin
          if (rx.bit_valid) begin
            // Right shift: after DATA_WIDTH bits the first bit sits at bit 0
            data_sh <= {rx.sampled_bit, data_sh[DATA_WIDTH-1:1]};
            run_par <= run_par ^ rx.sampled_bit;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (rx.bit_valid) begin
            // Even parity expects the data XOR; odd expects its inverse
            if (rx.sampled_bit != (run_par ^ par_type_q)) par_bad <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx.bit_valid) begin
            if (frame_end) begin
              state      <= S_IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              data_q     <= data_sh;
              par_err_q  <= par_bad;
              stop_err_q <= stop_flag;
            end else begin
              stop_bad <= stop_flag;
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating error counters; a clear wins over a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_cnt  <= '0;
      stop_cnt <= '0;
    end else if (rx.cnt_clr) begin
      par_cnt  <= '0;
      stop_cnt <= '0;
    end else if (frame_end) begin
      if (par_bad && (par_cnt != CNT_MAX))    par_cnt  <= par_cnt + 1'b1;
      if (stop_flag && (stop_cnt != CNT_MAX)) stop_cnt <= stop_cnt + 1'b1;
    end
  end

  assign rx.busy         = busy_q;
  assign rx.frame_done   = done_q;
  assign rx.data_out     = data_q;
  assign rx.par_err      = par_err_q;
  assign rx.stop_err     = stop_err_q;
  assign rx.par_err_cnt  = par_cnt;
  assign rx.stop_err_cnt = stop_cnt;
  assign state_dbg       = state;

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised UART receive frame checker: collects the sampled bits of one frame after the start bit, assembles the data word LSB-first, checks optional even/odd parity and one or two stop bits, and reports per-frame results. It also keeps saturating error counters. It sits between the RX bit sampler, which supplies one `sampled_bit` per `bit_valid` strobe, and the RX output register. It replaces the single-bit stop checker with a full frame-level check.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `CNT_WIDTH`, default 8: width of each error counter.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse, start bit confirmed by the sampler.
- `bit_valid` in 1: one-cycle strobe, `sampled_bit` is valid this cycle.
- `sampled_bit` in 1: mid-bit sample.
- `par_en` in 1: parity bit present; latched at `frame_start`.
- `par_type` in 1: 0 = even, 1 = odd; latched at `frame_start`.
- `cnt_clr` in 1: synchronous clear of both counters.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse; `data_out` and the error flags are valid.
- `data_out` out DATA_WIDTH: received word; holds until the next `frame_done`.
- `par_err` out 1: parity mismatch in the last frame; 0 when parity is disabled.
- `stop_err` out 1: at least one stop bit sampled 0 in the last frame.
- `par_err_cnt` out CNT_WIDTH: saturating count of frames with a parity error.
- `stop_err_cnt` out CNT_WIDTH: saturating count of frames with a stop error.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE → DATA on `frame_start`. In the same cycle: latch `par_en`/`par_type`, clear the bit counter, clear the running parity.
  - DATA: on each `bit_valid`, shift `sampled_bit` into bit position `bit_cnt` (LSB first) and XOR it into the running parity. After the DATA_WIDTH-th bit, go to PARITY if the latched `par_en` is 1, else to STOP.
  - PARITY: on `bit_valid`, the expected bit is running_parity XOR latched `par_type`. A mismatch sets internal `par_bad`. Then go to STOP.
  - STOP: on each `bit_valid`, a `sampled_bit` of 0 sets internal `stop_bad`. After STOP_BITS strobes, go to IDLE and complete the frame.
- Frame completion happens on the clock after the final stop `bit_valid`:
  - `frame_done`=1 for one cycle.
  - `data_out`, `par_err`, `stop_err` are loaded.
  - Each error counter increments by 1 if its flag is set, saturating at 2^CNT_WIDTH−1.
- All stop bits are checked; a 0 on the first stop bit does not shorten the frame.
- Cycles without `bit_valid` leave the state unchanged; there is no timeout.
- `frame_start` outside IDLE is ignored.
- `bit_valid` in IDLE is ignored.
- `busy`=1 in every state except IDLE.
- `cnt_clr` zeroes both counters. If it coincides with an increment, clear wins and the result is 0.
- Asserting `rst` at any time, including mid-frame, returns the block to IDLE. A partial frame produces no `frame_done`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `busy` 0, `frame_done` 0, `data_out` 0, `par_err` 0, `stop_err` 0, both counters 0.
- `busy` rises the cycle after `frame_start` and falls in the same cycle `frame_done` rises.
- Latency: `frame_done` is asserted exactly 1 cycle after the last stop-bit `bit_valid`.
- `par_err`/`stop_err` hold their values until the next `frame_done`. They are not cleared at `frame_start`.
- The counters update in the same cycle as `frame_done`.
- The block accepts a new `frame_start` in the cycle `frame_done` is high. It does not accept one earlier.
- `bit_valid` may be back-to-back: one bit per cycle is the minimum spacing supported.
- Frame length in `bit_valid` strobes: DATA_WIDTH + par_en + STOP_BITS.

## Test plan
- **Clean frame, no parity.** DATA_WIDTH=8, STOP_BITS=1, `par_en`=0, bits of 0xA5 LSB-first, then a stop bit of 1 → `frame_done` 1 cycle later, `data_out`=0xA5, `par_err`=0, `stop_err`=0, counters unchanged.
- **Parity check.** `par_en`=1, `par_type`=0, data 0x07:
  - parity bit 1 → `par_err`=0.
  - same data with parity bit 0 → `par_err`=1, `par_err_cnt`=1.
  - `par_type`=1 with parity bit 0 → `par_err`=0.
- **Two stop bits.** STOP_BITS=2, stop bits 1,0 → `stop_err`=1, `stop_err_cnt` increments. Stop bits 0,1 → `stop_err`=1. `frame_done` occurs only after the second stop strobe in both cases.
- **Counter saturation and clear.** CNT_WIDTH=2, five frames with a stop error → `stop_err_cnt`=3. Pulse `cnt_clr` on the same cycle as a sixth erroneous `frame_done` → count is 0.
- **Ignored events.**
  - `frame_start` pulsed mid-DATA → frame proceeds and the data is unaffected.
  - `bit_valid` pulses in IDLE → no state change, no `frame_done`.
  - `bit_valid` gaps of 0–15 cycles between bits → same result as back-to-back strobes.
- **Reset mid-frame.** Assert `rst` after 4 data bits → all outputs at reset values immediately (asynchronous). After release, a full frame 0x3C is received correctly with no spurious `frame_done`.
